// File: rtl/trans_responder.sv
// Target endpoint: executes addr/data/write/id requests against a 64x32 register store.
// Latency: response visible the cycle after the accept edge (registered FIFO, no bypass).
// Backpressure: req_ready drops only when the response FIFO is full; it never depends on rsp_ready.
module trans_responder #(
    parameter int MEM_WORDS = 64,
    parameter int RSP_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_data,
    input  logic        req_write,
    input  logic [31:0] req_id,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_write,
    output logic [31:0] rsp_id,
    output logic        rsp_err,
    output logic [15:0] txn_cnt
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [31:0] data;
        logic        write;
        logic [31:0] id;
        logic        err;
    } rsp_t;

    logic [31:0]   mem [MEM_WORDS];
    rsp_t          fifo_q [RSP_DEPTH];
    rsp_t          last_q;
    rsp_t          head;
    rsp_t          push_dat;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [5:0]    widx;
    logic          aligned;
    logic          accept;
    logic          pop;

    assign widx      = req_addr[7:2];
    assign aligned   = (req_addr[1:0] == 2'b00);
    assign req_ready = rstn && (fifo_cnt != CW'(RSP_DEPTH));
    assign rsp_valid = (fifo_cnt != '0);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;

    always_comb begin
        push_dat       = '0;
        push_dat.data  = (aligned && !req_write) ? mem[widx] : 32'h0;
        push_dat.write = req_write;
        push_dat.id    = req_id;
        push_dat.err   = !aligned;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (accept && aligned && req_write) begin
            mem[widx] <= req_data;
        end
    end

    // last_q keeps the most recently popped entry so the payload holds once the FIFO drains
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
            last_q   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (accept) begin
                fifo_q[wr_ptr] <= push_dat;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                last_q <= fifo_q[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({accept, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            txn_cnt <= '0;
        end else if (accept) begin
            txn_cnt <= txn_cnt + 1'b1;
        end
    end

    assign head      = rsp_valid ? fifo_q[rd_ptr] : last_q;
    assign rsp_data  = head.data;
    assign rsp_write = head.write;
    assign rsp_id    = head.id;
    assign rsp_err   = head.err;

endmodule
